// File: rtl/alu_operand_issue.sv
// Operand issue stage: decodes an R-type word, reads rs/rt from a 32x32 register file
// (with write-back bypass) and presents a held operand bundle to the ALU over valid/ready.
module alu_operand_issue #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Src1,
    output logic [31:0]      Src2,
    output logic [4:0]       Shamt,
    output logic [5:0]       Funct,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] ill_cnt
);

    logic [31:0]      rf_q [32];

    logic [5:0]       op;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             legal;
    logic             accept;
    logic             wb_hit;
    logic [31:0]      src1_d;
    logic [31:0]      src2_d;

    logic             valid_q;
    logic [31:0]      src1_q;
    logic [31:0]      src2_q;
    logic [4:0]       shamt_q;
    logic [5:0]       funct_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] ill_cnt_q;

    // Decode, handshake and operand read with same-cycle write-back bypass
    always_comb begin
        op       = instr[31:26];
        rs       = instr[25:21];
        rt       = instr[20:16];
        legal    = (op == 6'b000000);
        in_ready = !valid_q || out_ready;
        accept   = in_valid && in_ready;
        wb_hit   = wb_en && (wb_addr != 5'd0);

        if (rs == 5'd0) begin
            src1_d = 32'd0;
        end else if (wb_hit && (wb_addr == rs)) begin
            src1_d = wb_data;
        end else begin
            src1_d = rf_q[rs];
        end

        if (rt == 5'd0) begin
            src2_d = 32'd0;
        end else if (wb_hit && (wb_addr == rt)) begin
            src2_d = wb_data;
        end else begin
            src2_d = rf_q[rt];
        end
    end

    // Register file; entry 0 is never written so it stays zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wb_hit) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Output bundle: capture on legal accept, hold while stalled, drop when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            shamt_q <= 5'd0;
            funct_q <= 6'd0;
            rd_q    <= 5'd0;
        end else if (accept && legal) begin
            valid_q <= 1'b1;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            shamt_q <= instr[10:6];
            funct_q <= instr[5:0];
            rd_q    <= instr[15:11];
        end else if (out_ready) begin
            // Illegal accepts also land here: they never refill the bundle
            valid_q <= 1'b0;
        end
    end

    // Accepted / illegal instruction counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else if (accept) begin
            if (legal) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end else begin
                ill_cnt_q <= ill_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = valid_q;
    assign Src1      = src1_q;
    assign Src2      = src2_q;
    assign Shamt     = shamt_q;
    assign Funct     = funct_q;
    assign out_rd    = rd_q;
    assign acc_cnt   = acc_cnt_q;
    assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Randomised scoreboard bench for alu_operand_issue with a directed preamble.
module tb_alu_operand_issue;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   Src1;
    logic [31:0]   Src2;
    logic [4:0]    Shamt;
    logic [5:0]    Funct;
    logic [4:0]    out_rd;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] ill_cnt;

    alu_operand_issue #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Src1      (Src1),
        .Src2      (Src2),
        .Shamt     (Shamt),
        .Funct     (Funct),
        .out_rd    (out_rd),
        .acc_cnt   (acc_cnt),
        .ill_cnt   (ill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [4:0]  rd;
    } bundle_t;

    // Reference model: architectural registers, counters, and bundles awaiting the ALU
    bundle_t       exp_q[$];
    logic [31:0]   m_rf [32];
    logic [CW-1:0] m_acc;
    logic [CW-1:0] m_ill;
    bit            live = 1'b0;
    int            vectors = 0;
    int            errs = 0;
    bundle_t       mb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Architectural read as seen by an instruction issuing alongside a write-back
    function automatic logic [31:0] rd_model(input logic [4:0] a, input bit we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    // One clock of stimulus; the model absorbs the edge's effects right after it
    task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit we,
                        input logic [4:0] wa, input logic [31:0] wd, input bit ordy);
        bundle_t b;
        bit      acc;
        bit      leg;
        logic [5:0] opf;
        logic [4:0] f_rs;
        logic [4:0] f_rt;
        rst       = r;
        in_valid  = iv;
        instr     = ins;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        out_ready = ordy;
        opf  = ins[31:26];
        f_rs = ins[25:21];
        f_rt = ins[20:16];
        acc  = !r && iv && (exp_q.size() == 0 || ordy);
        leg  = (opf == 6'd0);
        b.s1 = rd_model(f_rs, we, wa, wd);
        b.s2 = rd_model(f_rt, we, wa, wd);
        b.sh = ins[10:6];
        b.fn = ins[5:0];
        b.rd = ins[15:11];
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_acc = '0;
            m_ill = '0;
            exp_q.delete();
            live = 1'b1;
        end else begin
            if (we && wa != 5'd0) m_rf[wa] = wd;
            if (acc) begin
                if (leg) begin
                    exp_q.push_back(b);
                    m_acc = m_acc + 1'b1;
                end else begin
                    m_ill = m_ill + 1'b1;
                end
            end
        end
    endtask

    // Monitor: compare the presented bundle and pop it when the ALU takes it
    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
            chk("acc_cnt", 32'(acc_cnt), 32'(m_acc));
            chk("ill_cnt", 32'(ill_cnt), 32'(m_ill));
            if (exp_q.size() != 0) begin
                mb = exp_q[0];
                chk("Src1", Src1, mb.s1);
                chk("Src2", Src2, mb.s2);
                chk("Shamt", 32'(Shamt), 32'(mb.sh));
                chk("Funct", 32'(Funct), 32'(mb.fn));
                chk("out_rd", 32'(out_rd), 32'(mb.rd));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [4:0]  a;
        logic [4:0]  bb;
        logic [4:0]  wa;

        step(1, 0, 32'd0, 0, 5'd0, 32'd0, 1);
        step(1, 0, 32'd0, 0, 5'd0, 32'd0, 1);
        chk("rst_Src1", Src1, 32'd0);
        chk("rst_Src2", Src2, 32'd0);
        chk("rst_Funct", 32'(Funct), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic issue after two write-backs
        step(0, 0, 32'd0, 1, 5'd1, 32'h0000_0005, 1);
        step(0, 0, 32'd0, 1, 5'd2, 32'h0000_0003, 1);
        step(0, 1, mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 5'd0, 32'd0, 1);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_Src1", Src1, 32'd5);
        chk("basic_Src2", Src2, 32'd3);
        chk("basic_Funct", 32'(Funct), 32'h20);
        chk("basic_rd", 32'(out_rd), 32'd3);
        chk("basic_acc", 32'(acc_cnt), 32'd1);

        // Bypass of a same-cycle write-back
        step(0, 1, mk(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h22), 1, 5'd1, 32'hFFFF_FFFF, 1);
        chk("bypass_Src1", Src1, 32'hFFFF_FFFF);

        // r0 ignores writes
        step(0, 0, 32'd0, 1, 5'd0, 32'h1234_5678, 1);
        step(0, 1, mk(6'd0, 5'd0, 5'd0, 5'd5, 5'd3, 6'h21), 0, 5'd0, 32'd0, 1);
        chk("r0_Src1", Src1, 32'd0);
        chk("r0_Src2", Src2, 32'd0);

        // Stall for three cycles, then consume and accept with no bubble
        for (int i = 0; i < 3; i++) begin
            step(0, 1, mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h24), 1, 5'd2, 32'hA5A5_0000, 0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_rd", 32'(out_rd), 32'd5);
        end
        step(0, 1, mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h24), 0, 5'd0, 32'd0, 1);
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_rd", 32'(out_rd), 32'd6);
        chk("nobubble_Src2", Src2, 32'hA5A5_0000);

        // Illegal opcode consumed, counted, never forwarded
        step(0, 1, mk(6'h23, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20), 0, 5'd0, 32'd0, 1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        chk("ill_cnt1", 32'(ill_cnt), 32'd1);
        chk("ill_acc", 32'(acc_cnt), 32'd4);

        // Reset with a pending bundle and a concurrent write-back
        step(0, 1, mk(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20), 0, 5'd0, 32'd0, 0);
        step(1, 1, mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20), 1, 5'd5, 32'hDEAD_BEEF, 0);
        chk("rstpend_valid", 32'(out_valid), 32'd0);
        chk("rstpend_acc", 32'(acc_cnt), 32'd0);
        chk("rstpend_ill", 32'(ill_cnt), 32'd0);
        step(0, 1, mk(6'd0, 5'd5, 5'd1, 5'd1, 5'd0, 6'h20), 0, 5'd0, 32'd0, 1);
        chk("rstpend_r5", Src1, 32'd0);
        chk("rstpend_r1", Src2, 32'd0);

        // Counter wrap: 16 more legal accepts bring a 4-bit counter back to 1
        for (int i = 0; i < 16; i++) begin
            step(0, 1, mk(6'd0, 5'(i), 5'(i + 1), 5'(i), 5'd0, 6'h25), 0, 5'd0, 32'd0, 1);
        end
        chk("wrap_acc", 32'(acc_cnt), 32'd1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            a  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            bb = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ins = mk(($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                     a, bb, 5'($urandom), 5'($urandom), 6'($urandom));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, ins,
                 $urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 9) < 7);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 0, 5'd0, 32'd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/alu_operand_issue.md
ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the accepted-instruction and illegal-instruction counters.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high; ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 instr  input  32  R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-008 wb_en  input  1  register write-back strobe from the ALU result path.
REQ-009 wb_addr  input  5  write-back register index.
REQ-010 wb_data  input  32  write-back value.
REQ-011 out_valid  output  1  operand bundle valid toward the ALU.
REQ-012 out_ready  input  1  ALU side consumes the bundle.
REQ-013 Src1, Src2  output  32 each  operand values of rs and rt.
REQ-014 Shamt  output  5; Funct  output  6; out_rd  output  5  fields carried with the bundle.
REQ-015 acc_cnt, ill_cnt  output  CNT_W each  accepted / illegal instruction counters.

Function
REQ-016 Register file: 32 x 32-bit; register 0 SHALL read as 0 and SHALL ignore writes.
REQ-017 Write-back: on a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] SHALL take wb_data.
REQ-018 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-019 Accept = in_valid && in_ready && !rst, evaluated at the rising edge.
REQ-020 Legal instruction: op==6'b000000; only legal instructions are forwarded.
REQ-021 Legal accept: on the next cycle, out_valid=1; Src1/Src2 = rs/rt values; Shamt/Funct/out_rd = instr fields; latency exactly 1 cycle.
REQ-022 Bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs (or rt) in the accepting cycle, the captured operand SHALL be wb_data, not the old register value.
REQ-023 Captured bundle SHALL be held stable while out_valid=1 and out_ready=0; later write-backs SHALL NOT alter it.
REQ-024 If out_valid=1, out_ready=1 and no new accept occurs, out_valid SHALL drop to 0 next cycle.
REQ-025 Simultaneous consume and accept: bundle replaced with no bubble; out_valid stays 1.
REQ-026 Illegal accept (op!=0): instruction consumed (in_ready honoured), out_valid SHALL NOT be set by it, ill_cnt SHALL increment; a pending bundle, if any, follows REQ-024.
REQ-027 acc_cnt SHALL increment on every legal accept; both counters SHALL wrap from all-ones to 0.
REQ-028 Write-back and accept in the same cycle SHALL both take effect.

Reset
REQ-029 While rst=1 at a rising edge: all 32 registers, Src1, Src2, Shamt, Funct, out_rd, acc_cnt, ill_cnt SHALL become 0; out_valid SHALL become 0.
REQ-030 Reset SHALL dominate: accepts and write-backs in a reset cycle SHALL be ignored; a pending bundle SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-032 Reset, then wb r1=32'h0000_0005, wb r2=32'h0000_0003, then instr rs=1 rt=2 rd=3 shamt=0 funct=6'h20 -> next cycle out_valid=1, Src1=5, Src2=3, Funct=6'h20, out_rd=3, acc_cnt=1.
REQ-033 Same cycle wb r1=32'hFFFF_FFFF and accept rs=1 -> Src1=32'hFFFF_FFFF (bypass).
REQ-034 wb r0=32'h1234_5678 then accept rs=0 rt=0 -> Src1=0, Src2=0.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle unchanged, acc_cnt unchanged; out_ready=1 -> next instruction bundle next cycle, out_valid stays 1.
REQ-036 instr op=6'h23 accepted -> out_valid stays 0, ill_cnt=1, acc_cnt unchanged.
REQ-037 rst=1 while out_valid=1 and wb_en=1 -> next cycle out_valid=0, target register reads 0, counters 0.
